// File: rtl/spi_shifter_if.sv
// spi_shifter_if: strobe/data/serial bundle between the ctrl decoder and the SPI byte shifter
interface spi_shifter_if;
  logic       WSTB;
  logic [7:0] WDATA;
  logic [1:0] DIV;
  logic       MISO;
  logic       SCK;
  logic       MOSI;
  logic       BUSY;
  logic       DONE;
  logic       OVR;
  logic [7:0] RDATA;
  modport master (output WSTB, WDATA, DIV, MISO, input SCK, MOSI, BUSY, DONE, OVR, RDATA);
  modport slave  (input WSTB, WDATA, DIV, MISO, output SCK, MOSI, BUSY, DONE, OVR, RDATA);
endinterface

// File: rtl/spi_shifter.sv
// spi_shifter: mode-0 SPI byte shifter, 16*H CLK cycles per byte.
// Optional SPI_CLKDIV_EN: H = 1<<DIV (1,2,4,8) via a 3-bit prescaler; otherwise H = 1.
module spi_shifter #(
  parameter bit MSB_FIRST = 1'b1
) (
  input logic         CLK,
  input logic         nRESET,
  spi_shifter_if.slave s
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
  state_t     state;
  logic [7:0] tx, rx, tx_n;
  logic [2:0] cnt;
  logic       accept, tick;
  // the DONE cycle is still treated as busy, so a strobe there is an overrun
  assign accept = s.WSTB && state == IDLE && !s.DONE;
  assign tx_n   = MSB_FIRST ? tx << 1 : tx >> 1;
`ifdef SPI_CLKDIV_EN
  logic [2:0] pre, h_max;
  logic [1:0] div_q;
  assign h_max = {div_q == 2'd3, div_q[1], |div_q};
  assign tick  = pre == h_max;
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) begin
      pre   <= 3'd0;
      div_q <= 2'd0;
    end else if (accept) begin
      pre   <= 3'd0;
      div_q <= s.DIV;
    end else if (state != IDLE) pre <= tick ? 3'd0 : pre + 3'd1;
`else
  assign tick = 1'b1;
`endif
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) begin
      state   <= IDLE;
      tx      <= 8'h00;
      rx      <= 8'h00;
      cnt     <= 3'd0;
      s.SCK   <= 1'b0;
      s.MOSI  <= 1'b0;
      s.BUSY  <= 1'b0;
      s.DONE  <= 1'b0;
      s.OVR   <= 1'b0;
      s.RDATA <= 8'h00;
    end else begin
      s.DONE <= 1'b0;
      if (s.WSTB) s.OVR <= !accept;
      case (state)
        IDLE: if (accept) begin
          state  <= LOW;
          tx     <= s.WDATA;
          cnt    <= 3'd0;
          s.BUSY <= 1'b1;
          s.MOSI <= MSB_FIRST ? s.WDATA[7] : s.WDATA[0];
        end
        LOW: if (tick) begin
          state <= HIGH;
          s.SCK <= 1'b1;
          rx    <= MSB_FIRST ? {rx[6:0], s.MISO} : {s.MISO, rx[7:1]};
        end
        HIGH: if (tick) begin
          s.SCK <= 1'b0;
          cnt   <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state   <= IDLE;
            s.BUSY  <= 1'b0;
            s.DONE  <= 1'b1;
            s.RDATA <= rx;
          end else begin
            state  <= LOW;
            tx     <= tx_n;
            s.MOSI <= MSB_FIRST ? tx_n[7] : tx_n[0];
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_shifter.sv
// tb_spi_shifter: drives MSB-first and LSB-first shifters with shared stimulus, checks against a byte-level model
module tb_spi_shifter;
  logic       CLK = 1'b0;
  logic       nRESET = 1'b0;
  int         n_tests = 0, n_fail = 0;
  logic [7:0] rd1 = 8'h00, rd0 = 8'h00;
  logic       ovr_exp = 1'b0;
  spi_shifter_if i1 ();
  spi_shifter_if i0 ();
  spi_shifter #(.MSB_FIRST(1'b1)) dut1 (.CLK(CLK), .nRESET(nRESET), .s(i1.slave));
  spi_shifter #(.MSB_FIRST(1'b0)) dut0 (.CLK(CLK), .nRESET(nRESET), .s(i0.slave));
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic wstb, input logic [7:0] wdata, input logic [1:0] div, input logic miso);
    i1.WSTB = wstb; i1.WDATA = wdata; i1.DIV = div; i1.MISO = miso;
    i0.WSTB = wstb; i0.WDATA = wdata; i0.DIV = div; i0.MISO = miso;
  endtask
  task automatic check_both(input string tag, input logic sck, input logic busy, input logic done,
                            input logic mosi1, input logic mosi0);
    check($sformatf("%s msb1", tag), {3'b0, i1.SCK, i1.MOSI, i1.BUSY, i1.DONE, i1.OVR, i1.RDATA},
          {3'b0, sck, mosi1, busy, done, ovr_exp, rd1});
    check($sformatf("%s msb0", tag), {3'b0, i0.SCK, i0.MOSI, i0.BUSY, i0.DONE, i0.OVR, i0.RDATA},
          {3'b0, sck, mosi0, busy, done, ovr_exp, rd0});
  endtask
  function automatic int hval(input logic [1:0] div);
`ifdef SPI_CLKDIV_EN
    return 1 << div;
`else
    return 1;
`endif
  endfunction
  // m[i] is the MISO level during the i-th bit period in time order
  function automatic logic [7:0] rx_of(input logic [7:0] m, input bit msb);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[msb ? 7 - i : i] = m[i];
    return r;
  endfunction
  task automatic xfer(input logic [7:0] d, input logic [1:0] div, input logic [7:0] m, input int sa, input int sb);
    int h, n, idx;
    logic st;
    h = hval(div);
    n = 16 * h;
    drive(1'b1, d, div, m[0]);
    @(posedge CLK); #1;
    ovr_exp = 1'b0;
    for (int c = 1; c <= n + 1; c++) begin
      idx = (c - 1) / (2 * h);
      if (idx > 7) idx = 7;
      st = (c == sa) || (c == sb);
      drive(st, ~d, div, m[idx]);
      @(negedge CLK);
      if (c <= n) check_both($sformatf("xfer %h c%0d", d, c), 1'(((c - 1) / h) % 2), 1'b1, 1'b0, d[7 - idx], d[idx]);
      else begin
        rd1 = rx_of(m, 1'b1);
        rd0 = rx_of(m, 1'b0);
        check_both($sformatf("done %h", d), 1'b0, 1'b0, 1'b1, d[0], d[7]);
      end
      @(posedge CLK); #1;
      if (st) ovr_exp = 1'b1;
    end
    drive(1'b0, d, div, 1'b0);
    @(negedge CLK);
    check_both($sformatf("idle %h", d), 1'b0, 1'b0, 1'b0, d[0], d[7]);
  endtask
  task automatic mid_reset(input logic [7:0] d, input logic [1:0] div);
    int h;
    h = hval(div);
    drive(1'b1, d, div, 1'b1);
    @(posedge CLK); #1;
    drive(1'b0, d, div, 1'b1);
    repeat (8 * h) @(posedge CLK);
    #2 nRESET = 1'b0;
    #1;
    rd1 = 8'h00; rd0 = 8'h00; ovr_exp = 1'b0;
    check_both("async rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge CLK); #1 nRESET = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check_both($sformatf("post rst %0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask
  initial begin
    logic [7:0] d, m;
    logic [1:0] div;
    int sa;
    drive(1'b0, 8'h00, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check_both($sformatf("reset %0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    @(posedge CLK); #1 nRESET = 1'b1;
    @(negedge CLK);
    check_both("released", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    xfer(8'hA5, 2'd0, 8'hA5, 0, 0);
    xfer(8'h3C, 2'd3, 8'hFF, 0, 0);
    xfer(8'h5A, 2'd0, 8'h96, 3, 16);
    xfer(8'h11, 2'd0, 8'h2B, 0, 17);
    xfer(8'h01, 2'd0, 8'h01, 0, 0);
    mid_reset(8'hC3, 2'd1);
    xfer(8'h81, 2'd0, 8'h81, 0, 0);
    for (int k = 0; k < 10; k++) begin
      d   = 8'($urandom);
      m   = 8'($urandom);
      div = 2'($urandom_range(0, 3));
      sa  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 16 * hval(div) + 1) : 0;
      xfer(d, div, m, sa, 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
